dsp_uart_tx: RTL and testbench
==============================

// Module: dsp_uart_tx
// PURPOSE
//  Display output stage downstream of the controller. Captures the 16-bit bus word on every
//  dsp_in_en pulse into a small FIFO, then serialises each word as 8N1 UART bytes on tx.
//  Decouples single-cycle OUT instructions from slow serial output; the CPU never stalls.
// PARAMETERS
//  CLK_DIV     16  clk cycles per UART bit (>=2)
//  FIFO_DEPTH  8   words buffered; power of two, >=2
//  LVL_W       4   width of level output; must equal log2(FIFO_DEPTH)+1
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      asynchronous, active-low reset
//  dsp_in_en  in   1      controller strobe: capture bus this cycle
//  bus        in   16     data bus (reg or memory output during OUT)
//  tx         out  1      UART serial line, idle high
//  busy       out  1      1 while a frame is in flight or FIFO non-empty
//  full       out  1      FIFO holds FIFO_DEPTH words
//  empty      out  1      FIFO holds no words
//  level      out  LVL_W  words currently queued
//  overflow   out  1      sticky: a write was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, busy=0, full=0, empty=1, level=0, overflow=0, state=IDLE,
//   FIFO pointers cleared. Mid-frame reset aborts the frame; tx returns high immediately.
//  Write: posedge with dsp_in_en=1 and full=0 pushes bus. If full=1 (value before this edge)
//   the word is dropped and overflow set; overflow clears only on reset. A pop in the same
//   cycle does not rescue a write to a full FIFO. Simultaneous push+pop when not full: level unchanged.
//  FSM: IDLE -> LOAD -> START -> DATA -> STOP -> (START | LOAD | IDLE).
//   IDLE : tx=1; if !empty go LOAD.
//   LOAD : pop head word into word register, byte index=0; tx=1; one cycle.
//   START: tx=0 for CLK_DIV cycles.
//   DATA : 8 bits LSB first, CLK_DIV cycles each; bit counter 0..7.
//   STOP : tx=1 for CLK_DIV cycles; then next byte of same word -> START (no gap);
//          last byte and !empty -> LOAD; else IDLE.
//  Baud counter counts 0..CLK_DIV-1, wraps, reloads to 0 on every state entry.
//  Latency: word written at edge N into empty FIFO, idle FSM -> tx falls at edge N+2.
//  Frame = 10*CLK_DIV cycles per byte; tx is registered (glitch-free).
//  busy = (state!=IDLE) | !empty.
// CONFIGURATION
//  DSP_HEX_EN undefined: 2 bytes per word, raw, bus[7:0] then bus[15:8].
//  DSP_HEX_EN defined: 5 bytes per word: 4 uppercase ASCII hex digits, MS nibble first
//   ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0A. Timing rules above unchanged.
// STRUCTURE
//  dsp_defs.v (shared include): FSM state encodings, UART_START/UART_STOP levels,
//   ASCII constants (0x30, 0x41, 0x0A), byte counts per word (2 raw / 5 hex).
//  Sub-module dsp_fifo: synchronous FIFO, FIFO_DEPTH x 16 with push/pop, full/empty/level.
//   Top holds FSM, baud counter, shift register, byte index, hex encoder.
// TESTING
//  1 Assert rst=0 mid-run -> tx=1, empty=1, level=0, overflow=0 same cycle.
//    After release with no writes -> tx stays 1.
//  2 CLK_DIV=4, write 0x1234 -> tx falls 2 cycles later; bytes 0x34 then 0x12.
//    Each is 40 cycles, no gap; busy drops after 80+1 cycles.
//  3 Pulse dsp_in_en 9 times back-to-back, depth 8 -> full=1 after 8th write;
//    9th dropped; overflow=1.
//    Exactly 8 words emitted, in order, with one idle LOAD cycle between words.
//  4 DSP_HEX_EN defined, write 0xBEEF -> bytes 0x42,0x45,0x45,0x46,0x0A.
//  5 Write during STOP of last byte while FIFO empty -> FSM goes LOAD (not IDLE).
//    The new word follows after a 1-cycle gap.
//  6 Push+pop same cycle at level=3 -> level stays 3; write at full coincident with pop
//    -> dropped, overflow=1.

Source files
------------

// File: rtl/dsp_uart_tx_pkg.sv
// Shared definitions for the display UART output stage: FSM states, line levels,
// ASCII constants, bytes per word and the hex-digit encoder.
package dsp_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic       UART_START = 1'b0;
  localparam logic       UART_STOP  = 1'b1;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [2:0] BYTES_RAW  = 3'd2;
  localparam logic [2:0] BYTES_HEX  = 3'd5;

  // Uppercase ASCII for one hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_ascii = ASCII_ZERO + {4'd0, nib};
    end else begin
      hex_ascii = ASCII_A + {4'd0, nib} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/dsp_uart_tx_fifo.sv
// Synchronous word FIFO with occupancy count; pushes to a full FIFO and pops from an
// empty FIFO are ignored. Read data is the head word, valid while not empty.
module dsp_uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [15:0]      wr_data,
  output logic [15:0]      rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_MAX);
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dsp_uart_tx.sv
// Display output stage: buffers bus words strobed by dsp_in_en and sends them as 8N1 bytes.
// Define DSP_HEX_EN to send each word as four ASCII hex digits plus newline instead of two raw bytes.
module dsp_uart_tx
  import dsp_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dsp_in_en,
  input  logic [15:0]      bus,
  output logic             tx,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

`ifdef DSP_HEX_EN
  localparam logic [2:0] BYTES_PER_WORD = BYTES_HEX;
`else
  localparam logic [2:0] BYTES_PER_WORD = BYTES_RAW;
`endif
  localparam int           BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  state_t      state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [2:0]  byte_idx, idx_n;
  logic [15:0] word, word_n;
  logic [15:0] head;
  logic [7:0]  cur_byte;
  logic        tx_n;
  logic        pop;
  logic        baud_done;

  dsp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (dsp_in_en),
    .pop     (pop),
    .wr_data (bus),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign busy      = (state != ST_IDLE) | ~empty;
  assign baud_done = (baud == BAUD_LAST);

  // Byte currently being framed, selected from the held word.
  always_comb begin
    cur_byte = 8'h00;
`ifdef DSP_HEX_EN
    case (byte_idx)
      3'd0:    cur_byte = hex_ascii(word[15:12]);
      3'd1:    cur_byte = hex_ascii(word[11:8]);
      3'd2:    cur_byte = hex_ascii(word[7:4]);
      3'd3:    cur_byte = hex_ascii(word[3:0]);
      default: cur_byte = ASCII_LF;
    endcase
`else
    if (byte_idx == 3'd0) begin
      cur_byte = word[7:0];
    end else begin
      cur_byte = word[15:8];
    end
`endif
  end

  // Next-state, counters and next line level.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    idx_n   = byte_idx;
    word_n  = word;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) state_n = ST_LOAD;
        else        state_n = ST_IDLE;
      end
      ST_LOAD: begin
        pop     = 1'b1;
        word_n  = head;
        idx_n   = 3'd0;
        state_n = ST_START;
      end
      ST_START: begin
        if (baud_done) begin
          state_n = ST_DATA;
          bit_n   = 3'd0;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_cnt == 3'd7) state_n = ST_STOP;
          else                 bit_n   = bit_cnt + 3'd1;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_STOP: begin
        if (!baud_done) begin
          state_n = ST_STOP;
        end else if (byte_idx != BYTES_PER_WORD - 3'd1) begin
          idx_n   = byte_idx + 3'd1;
          state_n = ST_START;
        end else if (!empty) begin
          state_n = ST_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Baud phase restarts whenever a new state is entered.
    if (state_n != state) begin
      baud_n = '0;
    end else if (baud_done) begin
      baud_n = '0;
    end else begin
      baud_n = baud + BAUD_ONE;
    end

    case (state_n)
      ST_START: tx_n = UART_START;
      ST_DATA:  tx_n = cur_byte[bit_n];
      default:  tx_n = UART_STOP;
    endcase
  end

  // Serialiser state; tx comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      word     <= 16'h0000;
      tx       <= UART_STOP;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      byte_idx <= idx_n;
      word     <= word_n;
      tx       <= tx_n;
      if (dsp_in_en && full) overflow <= 1'b1;
      else                   overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_dsp_uart_tx.sv
// Directed bench for dsp_uart_tx with a UART receiver monitor and expected-byte scoreboard.
module tb_dsp_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int LVL_W   = 4;
`ifdef DSP_HEX_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 2;
`endif
  localparam int FRAME  = 10 * CLK_DIV;
  localparam int WORD_T = BPW * FRAME;

  logic             clk;
  logic             rst;
  logic             dsp_in_en;
  logic [15:0]      bus;
  logic             tx;
  logic             busy;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  logic        mon_busy = 1'b0;

  dsp_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .LVL_W      (LVL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dsp_in_en (dsp_in_en),
    .bus       (bus),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_byte(input logic [15:0] w, input int k);
`ifdef DSP_HEX_EN
    logic [3:0] n;
    if (k == 4) return 8'h0A;
    n = 4'((w >> (12 - 4 * k)) & 16'h000F);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return 8'h37 + {4'd0, n};
`else
    if (k == 0) return w[7:0];
    return w[15:8];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  // Drive one strobe; it is captured at the next edge, leaving cyc equal to that edge.
  task automatic wr(input logic [15:0] w, input bit accepted);
    dsp_in_en = 1'b1;
    bus       = w;
    tick();
    dsp_in_en = 1'b0;
    if (accepted) begin
      for (int k = 0; k < BPW; k++) exp_q.push_back(model_byte(w, k));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || mon_busy) && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 4000), 32'd1);
    repeat (4) tick();
  endtask

  // Receiver: samples each bit mid-period on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin : rx_frame
        int         t0;
        logic [7:0] b;
        logic       stp;
        bit         ab;
        t0 = cyc;
        b = 8'h00;
        stp = 1'b0;
        ab = 1'b0;
        mon_busy = 1'b1;
        for (int k = 0; k < 9; k++) begin
          repeat ((k == 0) ? CLK_DIV + 1 : CLK_DIV) begin
            @(negedge clk);
            if (rst !== 1'b1) ab = 1'b1;
          end
          if (ab) break;
          if (k < 8) b[k] = tx;
          else       stp = tx;
        end
        if (!ab) begin
          starts.push_back(t0);
          chk("stop_bit", 32'(stp), 32'd1);
          if (exp_q.size() == 0) chk("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
          else                   chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int n0;
    bit ok;
    rst = 1'b0;
    dsp_in_en = 1'b0;
    bus = 16'h0000;
    repeat (3) tick();

    // Reset state
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (tx !== 1'b1) ok = 1'b0;
    end
    chk("idle_tx", 32'(ok), 32'd1);

    // Single word: latency, byte order, back-to-back bytes, busy release
    wr(16'h1234, 1'b1);
    n0 = cyc;
    tick();
    chk("lat_pre", 32'(tx), 32'd1);
    tick();
    chk("lat_fall", 32'(tx), 32'd0);
    goto(n0 + 1 + WORD_T);
    chk("busy_last", 32'(busy), 32'd1);
    tick();
    chk("busy_drop", 32'(busy), 32'd0);
    drain();
    chk("w1_nbytes", 32'(starts.size()), 32'(BPW));
    for (int k = 0; k < BPW && k < starts.size(); k++)
      chk("w1_start", 32'(starts[k]), 32'(n0 + 2 + k * FRAME));
    starts.delete();

    // Encoding of a second pattern
    wr(16'hBEEF, 1'b1);
    drain();
    starts.delete();

    // Write during the final stop bit goes straight to LOAD
    wr(16'hA55A, 1'b1);
    n0 = cyc;
    goto(n0 + WORD_T - 2);
    wr(16'h5AA5, 1'b1);
    drain();
    chk("stop_wr_n", 32'(starts.size()), 32'(2 * BPW));
    if (starts.size() > BPW)
      chk("stop_wr_gap", 32'(starts[BPW]), 32'(n0 + 3 + WORD_T));
    starts.delete();

    // Burst of nine writes while a frame is in flight: eight fit, ninth overflows
    wr(16'h0001, 1'b1);
    n0 = cyc;
    goto(n0 + 3);
    for (int i = 0; i < 9; i++) begin
      wr(16'h1100 + 16'(i * 16'h0111), i < 8);
      if (i == 6) chk("burst_full7", 32'(full), 32'd0);
      if (i == 7) begin
        chk("burst_full8", 32'(full), 32'd1);
        chk("burst_ovf8", 32'(overflow), 32'd0);
      end
    end
    chk("burst_level", 32'(level), 32'd8);
    chk("burst_ovf", 32'(overflow), 32'd1);
    drain();
    chk("burst_nbytes", 32'(starts.size()), 32'(9 * BPW));
    for (int w = 1; w < 9 && (w * BPW + 1) < starts.size(); w++) begin
      chk("burst_word_gap", 32'(starts[w * BPW] - starts[w * BPW - 1]), 32'(FRAME + 1));
      chk("burst_byte_gap", 32'(starts[w * BPW + 1] - starts[w * BPW]), 32'(FRAME));
    end
    starts.delete();

    // Reset in the middle of a frame
    wr(16'hC3C3, 1'b1);
    wr(16'h3C3C, 1'b1);
    n0 = cyc;
    goto(n0 + 3);
    chk("mid_tx_low", 32'(tx), 32'd0);
    chk("mid_ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (tx !== 1'b1) ok = 1'b0;
    end
    chk("mid_idle_tx", 32'(ok), 32'd1);
    starts.delete();

    // Push coincident with pop, then write at full coincident with pop
    wr(16'h000A, 1'b1);
    n0 = cyc;
    goto(n0 + 9);
    wr(16'h000B, 1'b1);
    wr(16'h000C, 1'b1);
    wr(16'h000D, 1'b1);
    goto(n0 + 2 + WORD_T);
    chk("pp_level_pre", 32'(level), 32'd3);
    wr(16'h000E, 1'b1);
    chk("pp_level", 32'(level), 32'd3);
    for (int i = 0; i < 5; i++) wr(16'h00F0 + 16'(i), 1'b1);
    chk("pp_full", 32'(full), 32'd1);
    goto(n0 + 3 + 2 * WORD_T);
    chk("pp_ovf_pre", 32'(overflow), 32'd0);
    wr(16'hDEAD, 1'b0);
    chk("pp_ovf", 32'(overflow), 32'd1);
    chk("pp_level_drop", 32'(level), 32'd7);
    drain();
    chk("pp_nbytes", 32'(starts.size()), 32'(10 * BPW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
